// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: control codes, FSM encoding
// and the default datapath width.
package alu_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MUL  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_NE   = 4'b1010;
  localparam logic [3:0] ALU_GEZ  = 4'b1011;
  localparam logic [3:0] ALU_GTZ  = 4'b1100;
  localparam logic [3:0] ALU_LEZ  = 4'b1101;
  localparam logic [3:0] ALU_LTZ  = 4'b1110;
  localparam logic [3:0] ALU_RSVD = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_exec_unit_mul.sv
// Iterative shift-add multiplier core (low word of the product).
// ALU_MUL_EARLY_EXIT_EN: also finish once the remaining multiplier is zero.
module mul_seq_core #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product
);

  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [DATA_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0]  cnt;

  logic                  running;
  logic                  last;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [DATA_WIDTH-1:0] mplier_next;

  // A non-zero counter is the only "in flight" indication; flush clears it.
  always_comb begin
    running     = (cnt != '0);
    mplier_next = mplier >> 1;
    acc_next    = mplier[0] ? (acc + mcand) : acc;
`ifdef ALU_MUL_EARLY_EXIT_EN
    last        = (cnt == CNT_WIDTH'(1)) || (mplier_next == '0);
`else
    last        = (cnt == CNT_WIDTH'(1));
`endif
    done        = running && last && !flush;
    product     = acc_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (flush) begin
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CNT_WIDTH'(DATA_WIDTH);
    end else if (running) begin
      mcand  <= mcand << 1;
      mplier <= mplier_next;
      acc    <= acc_next;
      cnt    <= last ? '0 : cnt - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops, iterative multiply, branch Zero flag.
// ALU_MUL_EARLY_EXIT_EN: multiply ends early once the multiplier runs out.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Flush,
  input  logic [3:0]            Ctrl,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [4:0]            Shamt,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Zero,
  output logic                  Done,
  output logic                  Busy,
  output logic                  Stall,
  output state_e                State
);

  // Handshake: an instruction is issued on any rising edge where Start=1,
  // Flush=0 and Busy=0; otherwise it is dropped, so upstream must hold it
  // while Stall=1. Done marks the single cycle in which Result/Zero are new.

  state_e                state;
  state_e                state_next;
  logic                  op_issue;
  logic                  mul_issue;
  logic                  mul_done;
  logic [DATA_WIDTH-1:0] mul_product;
  logic [DATA_WIDTH-1:0] op_result;
  logic                  a_neg;
  logic                  a_zero;
  logic                  is_mul;

  assign a_neg  = A[DATA_WIDTH-1];
  assign a_zero = (A == '0);
`ifdef ALU_MUL_EARLY_EXIT_EN
  // A zero multiplier completes like a single-cycle op with a zero result.
  assign is_mul = (Ctrl == ALU_MUL) && (B != '0);
`else
  assign is_mul = (Ctrl == ALU_MUL);
`endif

  assign Busy  = (state == ST_MUL);
  assign Stall = Busy || (Start && (Ctrl == ALU_MUL) && !Flush);
  assign State = state;

  // Branch codes yield 0 when the condition holds, so Zero=1 means taken.
  always_comb begin
    op_result = '0;
    case (Ctrl)
      ALU_ADD: op_result = A + B;
      ALU_SUB: op_result = A - B;
      ALU_AND: op_result = A & B;
      ALU_OR:  op_result = A | B;
      ALU_NOR: op_result = ~(A | B);
      ALU_XOR: op_result = A ^ B;
      ALU_SLL: op_result = B << Shamt;
      ALU_SRL: op_result = B >> Shamt;
      ALU_SLT: op_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_NE:  op_result = {{(DATA_WIDTH-1){1'b0}}, (A == B)};
      ALU_GEZ: op_result = {{(DATA_WIDTH-1){1'b0}}, a_neg};
      ALU_GTZ: op_result = {{(DATA_WIDTH-1){1'b0}}, (a_neg || a_zero)};
      ALU_LEZ: op_result = {{(DATA_WIDTH-1){1'b0}}, (!a_neg && !a_zero)};
      ALU_LTZ: op_result = {{(DATA_WIDTH-1){1'b0}}, !a_neg};
      default: op_result = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    op_issue   = 1'b0;
    mul_issue  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start && !Flush) begin
          if (is_mul) begin
            mul_issue  = 1'b1;
            state_next = ST_MUL;
          end else begin
            op_issue   = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (Flush || mul_done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Result <= '0;
      Zero   <= 1'b1;
      Done   <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (op_issue) begin
        Result <= op_result;
        Zero   <= (op_result == '0);
        Done   <= 1'b1;
      end else if (mul_done) begin
        Result <= mul_product;
        Zero   <= (mul_product == '0);
        Done   <= 1'b1;
      end
    end
  end

  mul_seq_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_mul (
    .clk    (Clk),
    .reset  (Reset),
    .start  (mul_issue),
    .flush  (Flush),
    .a      (A),
    .b      (B),
    .done   (mul_done),
    .product(mul_product)
  );

endmodule
